// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding, source-select width
// and default reset/exception addresses.
package pc_sequencer_pkg;

  localparam int unsigned SEL_W = 4;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_00FC;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXC_SAVE = 2'd1,
    EXC_VEC  = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_src_mux.sv
// Combinational N-input PC source selector; an out-of-range index yields zero and drops valid_o.
module pc_src_mux
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 6
) (
  input  logic [SEL_W-1:0]      sel_i,
  input  logic [NSRC*WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  valid_o
);

  always_comb begin
    data_o  = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (sel_i == SEL_W'(i)) begin
        data_o  = data_i[i*WIDTH +: WIDTH];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a three-state exception entry FSM (IDLE -> EXC_SAVE -> EXC_VEC).
// Optional target alignment checking is enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      NSRC       = 6,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEFAULT_EXC_VECTOR)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pc_write,
  input  logic [SEL_W-1:0]      src_sel,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic                  exc_req,
  input  logic                  eret,
  output logic [WIDTH-1:0]      pc_out,
  output logic [WIDTH-1:0]      pc_next,
  output logic [WIDTH-1:0]      epc_out,
  output logic                  exc_busy,
  output logic                  sel_fault,
  output logic                  align_fault
);

  if (NSRC < 2 || NSRC > 16) begin : gen_nsrc_check
    $error("pc_sequencer: NSRC must be in 2..16");
  end

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             sel_fault_q, sel_fault_d;
  logic             sel_valid;
  logic             idle;
  logic             align_trip;

  pc_src_mux #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC)
  ) u_src_mux (
    .sel_i   (src_sel),
    .data_i  (src_data),
    .data_o  (pc_next),
    .valid_o (sel_valid)
  );

  assign idle = (state_q == IDLE);

`ifdef PC_ALIGN_CHECK_EN
  logic align_fault_q;

  // Mirrors the IDLE priority: exc_req masks everything, eret masks pc_write, and a bad
  // select index is reported as sel_fault rather than an alignment exception.
  assign align_trip = idle && !exc_req &&
                      (eret ? (epc_q[1:0] != 2'b00)
                            : (pc_write && sel_valid && (pc_next[1:0] != 2'b00)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      align_fault_q <= 1'b0;
    end else begin
      align_fault_q <= align_trip;
    end
  end

  assign align_fault = align_fault_q;
`else
  assign align_trip  = 1'b0;
  assign align_fault = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    epc_d       = epc_q;
    sel_fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (exc_req || align_trip) begin
          state_d = EXC_SAVE;
        end else if (eret) begin
          pc_d = epc_q;
        end else if (pc_write) begin
          if (sel_valid) begin
            pc_d = pc_next;
          end else begin
            sel_fault_d = 1'b1;
          end
        end
      end
      EXC_SAVE: begin
        epc_d   = pc_q;
        state_d = EXC_VEC;
      end
      EXC_VEC: begin
        pc_d    = EXC_VECTOR;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      epc_q       <= '0;
      sel_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      sel_fault_q <= sel_fault_d;
    end
  end

  assign pc_out    = pc_q;
  assign epc_out   = epc_q;
  assign exc_busy  = (state_q == EXC_SAVE) || (state_q == EXC_VEC);
  assign sel_fault = sel_fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios followed by random traffic, checked
// against a cycle-level behavioural model of PC/EPC and exception progress.
module tb_pc_sequencer;

  localparam int unsigned W   = 32;
  localparam int unsigned N   = 6;
  localparam logic [W-1:0] EXC = 32'h0000_00FC;
  localparam logic [W-1:0] RST = 32'h0000_0000;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           pc_write = 1'b0;
  logic [3:0]     src_sel = 4'd0;
  logic [N*W-1:0] src_data = '0;
  logic           exc_req = 1'b0;
  logic           eret = 1'b0;
  logic [W-1:0]   pc_out, pc_next, epc_out;
  logic           exc_busy, sel_fault, align_fault;

  pc_sequencer #(
    .WIDTH      (W),
    .NSRC       (N),
    .RESET_PC   (RST),
    .EXC_VECTOR (EXC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pc_write    (pc_write),
    .src_sel     (src_sel),
    .src_data    (src_data),
    .exc_req     (exc_req),
    .eret        (eret),
    .pc_out      (pc_out),
    .pc_next     (pc_next),
    .epc_out     (epc_out),
    .exc_busy    (exc_busy),
    .sel_fault   (sel_fault),
    .align_fault (align_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [W-1:0] pc;
    logic [W-1:0] epc;
    logic [W-1:0] nxt;
    logic         busy;
    logic         sf;
    logic         af;
  } exp_t;

  exp_t         sb_q[$];
  int           tests = 0;
  int           fails = 0;
  int           step_id = 0;
  logic [W-1:0] src [N];

`ifdef PC_ALIGN_CHECK_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  // Model: architectural PC/EPC plus the number of cycles left in an exception entry
  logic [W-1:0] m_pc, m_epc;
  int           m_left;

  function automatic void chk(input string name, input int id, input logic [W-1:0] act,
                              input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endfunction

  task automatic step(input bit r, input bit x, input bit e, input bit w,
                      input logic [3:0] sel);
    exp_t ex;
    logic [W-1:0] tgt;
    bit ok;
    @(negedge clk);
    reset_n  = r;
    exc_req  = x;
    eret     = e;
    pc_write = w;
    src_sel  = sel;
    for (int i = 0; i < int'(N); i++) src_data[i*W +: W] = src[i];
    ok  = (int'(sel) < int'(N));
    tgt = ok ? src[sel] : '0;
    ex.nxt = tgt;
    ex.sf = 1'b0;
    ex.af = 1'b0;
    if (!r) begin
      m_pc = RST; m_epc = '0; m_left = 0;
    end else if (m_left == 2) begin
      m_epc = m_pc; m_left = 1;
    end else if (m_left == 1) begin
      m_pc = EXC; m_left = 0;
    end else if (x) begin
      m_left = 2;
    end else if (e) begin
      if (AlignEn && (m_epc % 4 != 0)) begin ex.af = 1'b1; m_left = 2; end
      else m_pc = m_epc;
    end else if (w) begin
      if (!ok) ex.sf = 1'b1;
      else if (AlignEn && (tgt % 4 != 0)) begin ex.af = 1'b1; m_left = 2; end
      else m_pc = tgt;
    end
    ex.id   = step_id++;
    ex.pc   = m_pc;
    ex.epc  = m_epc;
    ex.busy = (m_left != 0);
    sb_q.push_back(ex);
  endtask

  initial begin : monitor
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        ex = sb_q.pop_front();
        chk("pc_out", ex.id, pc_out, ex.pc);
        chk("epc_out", ex.id, epc_out, ex.epc);
        chk("pc_next", ex.id, pc_next, ex.nxt);
        chk("exc_busy", ex.id, W'(exc_busy), W'(ex.busy));
        chk("sel_fault", ex.id, W'(sel_fault), W'(ex.sf));
        chk("align_fault", ex.id, W'(align_fault), W'(ex.af));
      end
    end
  end

  initial begin : stimulus
    int waited;
    for (int i = 0; i < int'(N); i++) src[i] = 32'h1000 * (i + 1);
    m_pc = RST; m_epc = '0; m_left = 0;

    // Reset, then quiet cycles
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0, 0);

    // Valid write, then out-of-range select
    src[3] = 32'h0000_0040;
    step(1, 0, 0, 1, 4'd3);
    step(1, 0, 0, 1, 4'd7);
    step(1, 0, 0, 0, 4'd3);

    // Exception with a simultaneous write, requests while busy, then eret
    src[0] = 32'h0000_0080;
    step(1, 1, 0, 1, 4'd0);
    step(1, 1, 1, 1, 4'd0);
    step(1, 0, 1, 1, 4'd0);
    step(1, 0, 0, 0, 4'd0);
    step(1, 0, 1, 1, 4'd0);
    step(1, 0, 0, 0, 4'd0);

    // Reset landing while in EXC_VEC
    step(1, 1, 0, 0, 4'd0);
    step(1, 0, 0, 0, 4'd0);
    step(0, 0, 0, 0, 4'd0);
    step(1, 0, 0, 0, 4'd0);
    step(1, 0, 0, 0, 4'd0);

    // Misaligned write target from PC=0x40
    step(1, 0, 0, 1, 4'd3);
    src[1] = 32'h0000_0042;
    step(1, 0, 0, 1, 4'd1);
    repeat (3) step(1, 0, 0, 0, 4'd0);
    // Misaligned target with bad select: sel_fault only
    step(1, 0, 0, 1, 4'd9);
    step(1, 0, 0, 0, 4'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < int'(N); i++) begin
        src[i] = $urandom;
        if ($urandom_range(0, 2) != 0) src[i][1:0] = 2'b00;
      end
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1),
           4'($urandom_range(0, 15)));
    end

    waited = 0;
    while (sb_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (sb_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 32: PC/data width in bits.
REQ-002 The block SHALL have a parameter NSRC, default 6: number of PC source inputs, 2..16.
REQ-003 The block SHALL have a parameter RESET_PC, default 0: PC value after reset.
REQ-004 The block SHALL have a parameter EXC_VECTOR, default 32'h0000_00FC: exception handler address.
REQ-005 The block SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have a port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have a port pc_write, input, 1 bit: load PC from the selected source this cycle.
REQ-008 The block SHALL have a port src_sel, input, 4 bits: source index.
REQ-009 The block SHALL have a port src_data, input, NSRC*WIDTH bits: flattened sources, where source i occupies bits [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have a port exc_req, input, 1 bit: exception request (level, sampled in IDLE).
REQ-011 The block SHALL have a port eret, input, 1 bit: return from exception (PC <= EPC).
REQ-012 The block SHALL have a port pc_out, output, WIDTH bits: registered PC.
REQ-013 The block SHALL have a port pc_next, output, WIDTH bits: combinational selected source value (0 when src_sel >= NSRC).
REQ-014 The block SHALL have a port epc_out, output, WIDTH bits: registered EPC.
REQ-015 The block SHALL have a port exc_busy, output, 1 bit: high while in EXC_SAVE or EXC_VEC.
REQ-016 The block SHALL have a port sel_fault, output, 1 bit: one-cycle pulse for pc_write with src_sel >= NSRC.
REQ-017 The block SHALL have a port align_fault, output, 1 bit: one-cycle pulse for a misaligned target (see Configuration).

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, EXC_SAVE and EXC_VEC.
REQ-019 In IDLE the block SHALL apply the priority exc_req > eret > pc_write.
REQ-020 In IDLE, exc_req=1 SHALL transition to EXC_SAVE with no PC change that cycle.
REQ-021 In EXC_SAVE, EPC SHALL be loaded with pc_out and the FSM SHALL transition to EXC_VEC.
REQ-022 In EXC_VEC, PC SHALL be loaded with EXC_VECTOR and the FSM SHALL transition to IDLE.
REQ-023 Exception entry SHALL have a latency of exactly 3 edges from exc_req sampled to pc_out == EXC_VECTOR.
REQ-024 While exc_busy=1, pc_write, eret and exc_req SHALL be ignored, with no queuing.
REQ-025 In IDLE, eret=1 SHALL load PC with epc_out on the next edge; EPC SHALL be unchanged.
REQ-026 In IDLE, pc_write=1 with src_sel < NSRC SHALL load PC with pc_next on the next edge.
REQ-027 In IDLE, pc_write=1 with src_sel >= NSRC SHALL hold PC and assert sel_fault for one cycle.
REQ-028 With pc_write=0 and no event, PC and EPC SHALL hold.
REQ-029 Simultaneous exc_req and pc_write SHALL discard the write; EPC SHALL capture the pre-write PC.
REQ-030 Simultaneous eret and pc_write (no exc_req) SHALL perform eret only.
REQ-031 Values SHALL be WIDTH bits with no arithmetic and no wrap handling; EXC_VECTOR and RESET_PC SHALL be truncated to WIDTH.

Reset
REQ-032 reset_n=0 at an edge SHALL set pc_out=RESET_PC, epc_out=0, FSM=IDLE and sel_fault=align_fault=0.
REQ-033 Reset SHALL take precedence over all inputs, including mid-exception (EXC_SAVE/EXC_VEC aborted, EPC cleared).
REQ-034 exc_busy SHALL be 0 in the first cycle after reset.

Configuration
REQ-035 Macro PC_ALIGN_CHECK_EN defined: an IDLE pc_write or eret whose target has bits [1:0] != 0 SHALL NOT load PC, SHALL pulse align_fault, and SHALL enter EXC_SAVE (EPC = current PC).
REQ-036 Macro PC_ALIGN_CHECK_EN undefined: targets SHALL load unmodified and align_fault SHALL be tied 0.
REQ-037 If sel_fault and alignment both apply, sel_fault SHALL win and no exception is taken.

Structure
REQ-038 Package pc_sequencer_pkg SHALL hold the FSM state enum (IDLE, EXC_SAVE, EXC_VEC), SEL_W=4 and the default EXC_VECTOR/RESET_PC constants.
REQ-039 The combinational N-input selector SHALL be sub-module pc_src_mux (parameters WIDTH, NSRC; out-of-range yields 0).
REQ-040 The FSM, PC and EPC registers SHALL reside in pc_sequencer.

Verification
REQ-041 Reset release, no inputs -> pc_out=0, epc_out=0, exc_busy=0 for 5 cycles.
REQ-042 NSRC=6, src 3=32'h0000_0040, pc_write, src_sel=3 -> pc_out=0x40 next edge; src_sel=7 -> PC holds, sel_fault one cycle.
REQ-043 PC=0x40, exc_req plus pc_write (src=0x80) -> EPC=0x40 after edge 2, PC=0xFC after edge 3, exc_busy high 2 cycles; then eret -> PC=0x40.
REQ-044 Reset asserted during EXC_VEC -> pc_out=0, epc_out=0, IDLE; no 0xFC load.
REQ-045 With PC_ALIGN_CHECK_EN, PC=0x40, pc_write to 0x42 -> align_fault pulse, EPC=0x40, PC=0xFC; without the macro, PC=0x42.
